// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Shared types and constants for the serial arithmetic datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    // Bit-counter width for a given operand width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fulladder.sv
// ============================================================================
// Module : fulladder
// One-bit full-adder cell used by the bit-serial sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module : serial_add_ctrl
// Bit-serial add/subtract sequencer, LSB first, one full-adder cell.
// Optional zero flag enabled by defining SERIAL_ADD_ZERO_FLAG_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow
`ifdef SERIAL_ADD_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int             CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               cell_sum;
    logic               cell_cout;
    logic               accept;
    logic               last_bit;

    fulladder u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    assign accept   = (state == IDLE) && start;
    assign last_bit = (cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Subtraction folds into the add: invert B and seed the carry with 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh     <= '0;
            b_sh     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_sh     <= a;
            b_sh     <= b ^ {WIDTH{op_sub}};
            carry    <= op_sub;
            cnt      <= '0;
            result   <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else if (state == RUN) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            result <= {cell_sum, result[WIDTH-1:1]};
            carry  <= cell_cout;
            cnt    <= cnt + 1'b1;
            if (last_bit) begin
                c_out    <= cell_cout;
                overflow <= carry ^ cell_cout;
            end
        end
    end

`ifdef SERIAL_ADD_ZERO_FLAG_EN
    // Accumulate "all sum bits zero" privately so the visible flag only rises at done.
    logic zero_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            zero_acc <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            zero_acc <= 1'b1;
            zero     <= 1'b0;
        end else if (state == RUN) begin
            zero_acc <= zero_acc & ~cell_sum;
            if (last_bit) begin
                zero <= zero_acc & ~cell_sum;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// Module : tb_serial_add_ctrl
// Self-checking bench for serial_add_ctrl (WIDTH=16).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic [W-1:0] result;
    logic         c_out;
    logic         overflow;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
    logic         zero;
`endif

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op_sub   (op_sub),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .c_out    (c_out),
        .overflow (overflow)
`ifdef SERIAL_ADD_ZERO_FLAG_EN
        ,
        .zero     (zero)
`endif
    );

    typedef struct packed {
        logic         sub;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        logic         z;
    } exp_t;

    exp_t sb[$];
    vec_t tv[11];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    function automatic exp_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t         e;
        logic [W-1:0] yy;
        logic [W:0]   t;
        yy    = s ? ~y : y;
        t     = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
        e.res = t[W-1:0];
        e.co  = t[W];
        e.ov  = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
        e.z   = (t[W-1:0] == '0);
        return e;
    endfunction

    task automatic wait_ready();
        int g = 0;
        while (!ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic compare_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_result"}, 32'(result), 32'(e.res));
            check({tag, "_c_out"}, 32'(c_out), 32'(e.co));
            check({tag, "_overflow"}, 32'(overflow), 32'(e.ov));
`ifdef SERIAL_ADD_ZERO_FLAG_EN
            check({tag, "_zero"}, 32'(zero), 32'(e.z));
`endif
        end
    endtask

    // Waits for done; returns how many negedges elapsed (cycles already counted is the start).
    task automatic wait_done(input int from, output int cycles);
        cycles = from;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic run_op(input string tag, input logic s, input logic [W-1:0] x,
                          input logic [W-1:0] y, input exp_t e);
        int cyc;
        wait_ready();
        start  = 1'b1;
        op_sub = s;
        a      = x;
        b      = y;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        wait_done(1, cyc);
        check({tag, "_latency"}, 32'(cyc), 32'(W + 1));
        compare_pop(tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_ready_back"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int   cyc;
        int   seen;
        exp_t e;

        reset  = 1'b1;
        start  = 1'b0;
        op_sub = 1'b0;
        a      = '0;
        b      = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_c_out", 32'(c_out), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        tv = '{
            '{1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0},
            '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0},
            '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1},
            '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0},
            '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1},
            '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1},
            '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0},
            '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0},
            '{1'b1, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b1},
            '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0},
            '{1'b0, 16'h0001, 16'h0000, 16'h0001, 1'b0, 1'b0}
        };

        for (int i = 0; i < 11; i++) begin
            e.res = tv[i].res;
            e.co  = tv[i].co;
            e.ov  = tv[i].ov;
            e.z   = (tv[i].res == '0);
            run_op($sformatf("vec%0d", i), tv[i].sub, tv[i].x, tv[i].y, e);
        end

        for (int i = 0; i < 6; i++) begin
            logic         s;
            logic [W-1:0] x;
            logic [W-1:0] y;
            s = 1'($urandom);
            x = W'($urandom);
            y = W'($urandom);
            run_op($sformatf("rnd%0d", i), s, x, y, model(s, x, y));
        end

        // start held high with operands changing mid-run: only the first pair counts.
        wait_ready();
        start  = 1'b1;
        op_sub = 1'b0;
        a      = 16'h0102;
        b      = 16'h0304;
        sb.push_back(model(1'b0, 16'h0102, 16'h0304));
        @(negedge clk);
        cyc  = 1;
        seen = 0;
        while (!done && cyc < 40) begin
            if (ready) seen++;
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
            cyc++;
        end
        check("hold_latency", 32'(cyc), 32'(W + 1));
        check("hold_ready_low", 32'(seen), 32'd0);
        compare_pop("hold_first");
        a = 16'h0100;
        b = 16'h0022;
        sb.push_back(model(1'b0, 16'h0100, 16'h0022));
        @(negedge clk);
        check("hold_ready_return", 32'(ready), 32'd1);
        @(negedge clk);
        start = 1'b0;
        wait_done(2, cyc);
        check("hold_throughput", 32'(cyc), 32'(W + 2));
        compare_pop("hold_second");
        @(negedge clk);

        // Reset eight cycles into RUN aborts without a done pulse.
        wait_ready();
        start  = 1'b1;
        op_sub = 1'b0;
        a      = 16'h1111;
        b      = 16'h2222;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_in_run", 32'(ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_result", 32'(result), 32'd0);
        check("abort_c_out", 32'(c_out), 32'd0);
        check("abort_overflow", 32'(overflow), 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) seen++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(seen), 32'd0);
        e = '{res: 16'h0007, co: 1'b0, ov: 1'b0, z: 1'b0};
        run_op("after_abort", 1'b0, 16'h0003, 16'h0004, e);

        // start and reset together: reset wins and nothing is launched.
        start = 1'b1;
        reset = 1'b1;
        a     = 16'h0005;
        b     = 16'h0005;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        check("rst_start_ready", 32'(ready), 32'd1);
        check("rst_start_result", 32'(result), 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || !ready) seen++;
            @(negedge clk);
        end
        check("rst_start_idle", 32'(seen), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
